// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - RV32I instruction fetch stage with credit-limited request queue
//
// Holds the fetch PC, issues word reads over a req/gnt/rvalid handshake,
// buffers returned words in an in-order queue and presents the head entry
// with its PC and pre-split opcode/funct3/funct7 fields to decode.
//
// Optional feature macro: IFU_MISALIGN_TRAP_EN
//   defined   : a redirect target with bits [1:0] != 00 sets the sticky
//               misalign flag and halts further fetching until reset.
//   undefined : redirect_pc[1:0] is ignored and misalign is tied low.
//
// Parameters:
//   RESET_PC     first fetch address after reset
//   DEPTH        queue entries and max outstanding requests (power of 2, >= 2)
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   imem_req/addr/gnt          fetch request channel
//   imem_rvalid/rdata          in-order fetch response channel
//   redirect, redirect_pc      taken branch/jump from execute
//   id_valid/id_ready          head-of-queue handshake to decode
//   id_instr, id_pc            head instruction and its address
//   id_pc_plus4                id_pc + 4
//   id_opcode/funct3/funct7    instruction fields of id_instr
//   misalign                   sticky misaligned-redirect flag

module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7,
    output logic        misalign
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;

    // Addresses of granted, not-yet-answered, non-discarded requests.
    logic [31:0]   addr_fifo [DEPTH];
    logic [AW-1:0] af_wr;
    logic [AW-1:0] af_rd;

    // Instruction queue of {pc, instr}.
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [AW-1:0] q_wr;
    logic [AW-1:0] q_rd;
    logic [CW-1:0] q_cnt;

    logic          halted;
    logic [CW:0]   in_flight;
    logic          credit_ok;
    logic          grant;
    logic          drop;
    logic          q_push;
    logic          q_pop;
    logic [CW-1:0] remaining;
    logic [31:0]   target_pc;

    assign target_pc = {redirect_pc[31:2], 2'b00};

`ifdef IFU_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
            halted     <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
            halted     <= 1'b1;
        end
    end

    assign misalign = misalign_q;
`else
    logic unused_low_bits;

    assign unused_low_bits = ^redirect_pc[1:0];
    assign halted          = 1'b0;
    assign misalign        = 1'b0;
`endif

    // Outstanding requests (including those awaiting discard) plus buffered
    // entries must never exceed DEPTH, so every response has a queue slot.
    always_comb begin
        in_flight = {1'b0, outstanding} + {1'b0, q_cnt};
        credit_ok = in_flight < (CW + 1)'(DEPTH);
        imem_req  = ~reset & ~redirect & ~halted & credit_ok;
        grant     = imem_req & imem_gnt;
        drop      = imem_rvalid & (discard != '0);
        q_push    = imem_rvalid & ~drop;
        id_valid  = (q_cnt != '0) & ~redirect;
        q_pop     = id_valid & id_ready;
        // A response arriving in the redirect cycle is already stale and is
        // retired here rather than counted as a future discard.
        remaining = outstanding - CW'(imem_rvalid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            af_wr       <= '0;
            af_rd       <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
            q_cnt       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_fifo[i] <= '0;
                q_pc[i]      <= '0;
                q_instr[i]   <= '0;
            end
        end else if (redirect) begin
            fetch_pc    <= target_pc;
            outstanding <= remaining;
            discard     <= remaining;
            af_wr       <= '0;
            af_rd       <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
            q_cnt       <= '0;
        end else begin
            if (grant) begin
                fetch_pc         <= fetch_pc + 32'd4;
                addr_fifo[af_wr] <= fetch_pc;
                af_wr            <= af_wr + AW'(1);
            end
            if (drop) begin
                discard <= discard - CW'(1);
            end
            if (q_push) begin
                q_pc[q_wr]    <= addr_fifo[af_rd];
                q_instr[q_wr] <= imem_rdata;
                q_wr          <= q_wr + AW'(1);
                af_rd         <= af_rd + AW'(1);
            end
            if (q_pop) begin
                q_rd <= q_rd + AW'(1);
            end
            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
            q_cnt       <= q_cnt + CW'(q_push) - CW'(q_pop);
        end
    end

    assign imem_addr   = fetch_pc;
    assign id_instr    = q_instr[q_rd];
    assign id_pc       = q_pc[q_rd];
    assign id_pc_plus4 = id_pc + 32'd4;
    assign id_opcode   = id_instr[6:0];
    assign id_funct3   = id_instr[14:12];
    assign id_funct7   = id_instr[31:25];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - scoreboard testbench for inst_fetch_unit
module tb_inst_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    inst_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_opcode   (id_opcode),
        .id_funct3   (id_funct3),
        .id_funct7   (id_funct7),
        .misalign    (misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3355;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: in-order responses, fixed latency in cycles after grant.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    resp_t pend[$];
    int    lat       = 1;
    int    ecount    = 0;
    int    grant_cnt = 0;

    always begin
        @(negedge clk);
        #2;
        if (reset) begin
            pend.delete();
            grant_cnt = 0;
        end else if (imem_req && imem_gnt) begin
            pend.push_back('{addr: imem_addr, due: ecount + lat});
            grant_cnt++;
        end
        @(posedge clk);
        ecount++;
        #1;
        if (pend.size() != 0 && pend[0].due <= ecount) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    // Scoreboard monitor: each transfer to decode pops one expected PC.
    logic [31:0] exp_q[$];

    always begin
        logic [31:0] e;
        logic [31:0] w;
        @(negedge clk);
        #2;
        if (!reset && id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_instr actual_pc=%h required=none at %0t", id_pc, $time);
            end else begin
                e = exp_q.pop_front();
                w = mem_word(e);
                chk("id_pc", id_pc, e);
                chk("id_instr", id_instr, w);
                chk("id_pc_plus4", id_pc_plus4, e + 32'd4);
                chk("id_opcode", {25'd0, id_opcode}, {25'd0, w[6:0]});
                chk("id_funct3", {29'd0, id_funct3}, {29'd0, w[14:12]});
                chk("id_funct7", {25'd0, id_funct7}, {25'd0, w[31:25]});
            end
        end
    end

    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + 32'd4;
        end
    endtask

    // Called at a falling edge; lets exactly the queued expectations through.
    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        id_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
            n++;
            if (n > budget) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout actual_left=%0d required=0", name, exp_q.size());
                exp_q.delete();
                break;
            end
        end
        id_ready = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        imem_gnt    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_pc_plus4", id_pc_plus4, 32'h4);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);

        // Release: request to RESET_PC immediately, grant next edge,
        // response the edge after, head valid after that.
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        @(negedge clk);
        #1;
        chk("early_id_valid", {31'd0, id_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("first_id_valid", {31'd0, id_valid}, 32'd1);
        chk("first_id_pc", id_pc, 32'h0);

        // Decode stalled: only DEPTH requests granted, then request stops.
        repeat (8) @(negedge clk);
        #1;
        chk("stall_grants", grant_cnt, 32'd2);
        chk("stall_req_low", {31'd0, imem_req}, 32'd0);

        // Release: 0,4 from the queue, fetch resumes at 8.
        @(negedge clk);
        push_seq(32'h0, 12);
        drain("stream", 200);

        // Redirect to 0x100 with two requests outstanding and no response yet.
        repeat (8) @(negedge clk);
        lat = 4;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("redir_req_low", {31'd0, imem_req}, 32'd0);
        chk("redir_id_valid_low", {31'd0, id_valid}, 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        push_seq(32'h100, 4);
        drain("redir2", 200);

        // Redirect coinciding with the only outstanding response.
        repeat (10) @(negedge clk);
        lat = 2;
        repeat (4) @(negedge clk);
        imem_gnt = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        redirect = 1'b0;
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h400;
        @(negedge clk);
        redirect = 1'b0;
        imem_gnt = 1'b1;
        push_seq(32'h400, 4);
        drain("redir_same", 200);

        // Address wrap at the top of the address space.
        repeat (6) @(negedge clk);
        lat = 1;
        repeat (4) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect = 1'b0;
        push_seq(32'hFFFF_FFF8, 4);
        drain("wrap", 200);

        // Misaligned redirect target.
        repeat (6) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h102;
        @(negedge clk);
        redirect = 1'b0;
        #1;
`ifdef IFU_MISALIGN_TRAP_EN
        chk("misalign_set", {31'd0, misalign}, 32'd1);
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("halted_req", {31'd0, imem_req}, 32'd0);
            chk("halted_id_valid", {31'd0, id_valid}, 32'd0);
        end
        @(negedge clk);
        id_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("misalign_cleared", {31'd0, misalign}, 32'd0);
`else
        chk("misalign_ignored", {31'd0, misalign}, 32'd0);
        @(negedge clk);
        push_seq(32'h100, 3);
        drain("misalign_aligned", 200);
`endif

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
